// File: rtl/ccd_test_sequencer.sv
// ccd_test_sequencer
//   Programmable CCD/ADC functional-test sequencer. Pulls DAC codes from a
//   show-ahead FIFO, drives the BOS analog front-end strobes and the DAC, and
//   captures one ADC word per pixel into a valid-strobed output stream.
//
//   Ports
//     sys_clk, n_rst        clock, asynchronous active-low reset
//     cfg_wr/addr/data      config register write (accepted in IDLE only)
//     start, stop           run start (IDLE only), abort (any state, wins over start)
//     smp_data/empty/rdreq  show-ahead sample FIFO interface (rdreq is combinational)
//     dac_d                 DAC code
//     clk_fpga/shp/shd_fpga BOS strobes, high whenever not running
//     adc_q                 BOS parallel output, already in sys_clk domain
//     cap_data/cap_valid    captured sample (zero-extended) and its strobe
//     busy, done, underflow state != IDLE, completion pulse, sticky FIFO underflow
//
//   Register map (16 bit each)
//     0 mode (bit0: 1 = CCD, 0 = plain)   1 black level    2 per_last
//     3 shp {hi,lo}   4 shd {hi,lo}   5 {cap_pos, clk_fall}   6 pix_cnt
//   per_last, black and pix_cnt keep only PH_W, DAC_W and CNT_W bits.
//   Requires DAC_W, ADC_W, CNT_W <= 16.
module ccd_test_sequencer #(
  parameter int DAC_W = 14,
  parameter int ADC_W = 12,
  parameter int PH_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             sys_clk,
  input  logic             n_rst,
  input  logic             cfg_wr,
  input  logic [2:0]       cfg_addr,
  input  logic [15:0]      cfg_data,
  input  logic             start,
  input  logic             stop,
  input  logic [DAC_W-1:0] smp_data,
  input  logic             smp_empty,
  output logic             smp_rdreq,
  output logic [DAC_W-1:0] dac_d,
  output logic             clk_fpga,
  output logic             shp_fpga,
  output logic             shd_fpga,
  input  logic [ADC_W-1:0] adc_q,
  output logic [15:0]      cap_data,
  output logic             cap_valid,
  output logic             busy,
  output logic             done,
  output logic             underflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    ph_q, ph_d;
  logic [CNT_W-1:0]   pix_q, pix_d;
  logic [DAC_W-1:0]   hold_q, hold_d;
  logic               done_q, done_d;
  logic               uf_q, uf_d;

  // config registers
  logic               mode_q, mode_d;
  logic [DAC_W-1:0]   black_q, black_d;
  logic [PH_W-1:0]    per_q, per_d;
  logic [15:0]        shp_q, shp_d, shd_q, shd_d, capclk_q, capclk_d;
  logic [CNT_W-1:0]   pixn_q, pixn_d;

  // registered front-end outputs
  logic               clk_fpga_q, clk_fpga_d, shp_fpga_q, shp_fpga_d, shd_fpga_q, shd_fpga_d;
  logic [DAC_W-1:0]   dac_d_q, dac_d_d;
  logic [15:0]        cap_data_q, cap_data_d;
  logic               cap_valid_q, cap_valid_d;

  // stop suppresses all RUN-side effects in its own cycle, so an aborted
  // pixel never pops, captures or flags underflow
  logic               run_act, fetch, last_ph, last_pix;
  logic [15:0]        ph16, clk_fall, cap_pos;
  logic [CNT_W-1:0]   pix_tgt;

  assign ph16     = 16'(ph_q);
  assign clk_fall = {8'd0, capclk_q[7:0]};
  assign cap_pos  = {8'd0, capclk_q[15:8]};
  assign pix_tgt  = pixn_q - CNT_W'(1);
  assign run_act  = (state_q == RUN) && !stop;
  assign last_ph  = (ph_q == per_q);
  assign last_pix = (pix_q == pix_tgt);
  assign fetch    = run_act && (ph_q == '0);

  assign smp_rdreq = fetch && !smp_empty;

  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    pix_d    = pix_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    uf_d     = uf_q;
    mode_d   = mode_q;
    black_d  = black_q;
    per_d    = per_q;
    shp_d    = shp_q;
    shd_d    = shd_q;
    capclk_d = capclk_q;
    pixn_d   = pixn_q;

    if (state_q == IDLE && cfg_wr) begin
      case (cfg_addr)
        3'd0:    mode_d   = cfg_data[0];
        3'd1:    black_d  = cfg_data[DAC_W-1:0];
        3'd2:    per_d    = cfg_data[PH_W-1:0];
        3'd3:    shp_d    = cfg_data;
        3'd4:    shd_d    = cfg_data;
        3'd5:    capclk_d = cfg_data;
        3'd6:    pixn_d   = cfg_data[CNT_W-1:0];
        default: ;
      endcase
    end

    case (state_q)
      IDLE: if (start) begin
        if (pixn_q == '0) done_d = 1'b1;
        else begin
          state_d = PRIME;
          uf_d    = 1'b0;
          pix_d   = '0;
        end
      end
      PRIME: if (!smp_empty) begin
        state_d = RUN;
        ph_d    = '0;
      end
      RUN: begin
        ph_d = last_ph ? '0 : ph_q + PH_W'(1);
        if (last_ph) begin
          if (last_pix) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else pix_d = pix_q + CNT_W'(1);
        end
        // an empty FIFO still counts the pixel; hold keeps the last code
        if (fetch) begin
          if (smp_empty) uf_d = 1'b1;
          else hold_d = smp_data;
        end
      end
      default: state_d = IDLE;
    endcase

    if (stop) begin
      state_d = IDLE;
      ph_d    = '0;
      pix_d   = pix_q;
      done_d  = 1'b0;
      uf_d    = uf_q;
    end
  end

  // strobes and DAC follow ph by one clock; hold_d lets the DAC show the
  // sample fetched in the same pixel
  always_comb begin
    clk_fpga_d  = 1'b1;
    shp_fpga_d  = 1'b1;
    shd_fpga_d  = 1'b1;
    dac_d_d     = black_q;
    cap_valid_d = 1'b0;
    cap_data_d  = cap_data_q;
    if (run_act) begin
      clk_fpga_d  = ph16 < clk_fall;
      shp_fpga_d  = !((ph16 >= {8'd0, shp_q[7:0]}) && (ph16 < {8'd0, shp_q[15:8]}));
      shd_fpga_d  = !((ph16 >= {8'd0, shd_q[7:0]}) && (ph16 < {8'd0, shd_q[15:8]}));
      dac_d_d     = (mode_q && (ph16 < clk_fall)) ? black_q : hold_d;
      cap_valid_d = (ph16 == cap_pos);
      if (cap_valid_d) cap_data_d = 16'(adc_q);
    end
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      ph_q        <= '0;
      pix_q       <= '0;
      hold_q      <= '0;
      done_q      <= 1'b0;
      uf_q        <= 1'b0;
      mode_q      <= 1'b1;
      black_q     <= '0;
      per_q       <= PH_W'(7);
      shp_q       <= 16'h0301;
      shd_q       <= 16'h0705;
      capclk_q    <= 16'h0704;
      pixn_q      <= '0;
      clk_fpga_q  <= 1'b0;
      shp_fpga_q  <= 1'b0;
      shd_fpga_q  <= 1'b0;
      dac_d_q     <= '0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ph_q        <= ph_d;
      pix_q       <= pix_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      uf_q        <= uf_d;
      mode_q      <= mode_d;
      black_q     <= black_d;
      per_q       <= per_d;
      shp_q       <= shp_d;
      shd_q       <= shd_d;
      capclk_q    <= capclk_d;
      pixn_q      <= pixn_d;
      clk_fpga_q  <= clk_fpga_d;
      shp_fpga_q  <= shp_fpga_d;
      shd_fpga_q  <= shd_fpga_d;
      dac_d_q     <= dac_d_d;
      cap_data_q  <= cap_data_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign dac_d     = dac_d_q;
  assign clk_fpga  = clk_fpga_q;
  assign shp_fpga  = shp_fpga_q;
  assign shd_fpga  = shd_fpga_q;
  assign cap_data  = cap_data_q;
  assign cap_valid = cap_valid_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_ccd_test_sequencer.sv
// Bench for ccd_test_sequencer. The reference describes each run as a
// timeline: cycle 0 is the start cycle, then PRIME cycles, then RUN cycles
// numbered t, with pixel = t / period and phase = t % period. Expected outputs
// follow from those plus the programmed register values.
module tb_ccd_test_sequencer;
  logic        sys_clk = 1'b0, n_rst = 1'b0;
  logic        cfg_wr = 1'b0;
  logic [2:0]  cfg_addr = '0;
  logic [15:0] cfg_data = '0;
  logic        start = 1'b0, stop = 1'b0;
  logic [13:0] smp_data;
  logic        smp_empty, smp_rdreq;
  logic [13:0] dac_d;
  logic        clk_fpga, shp_fpga, shd_fpga;
  logic [11:0] adc_q = '0;
  logic [15:0] cap_data;
  logic        cap_valid, busy, done, underflow;

  ccd_test_sequencer #(.DAC_W(14), .ADC_W(12), .PH_W(8), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .n_rst(n_rst), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .start(start), .stop(stop), .smp_data(smp_data),
    .smp_empty(smp_empty), .smp_rdreq(smp_rdreq), .dac_d(dac_d),
    .clk_fpga(clk_fpga), .shp_fpga(shp_fpga), .shd_fpga(shd_fpga),
    .adc_q(adc_q), .cap_data(cap_data), .cap_valid(cap_valid), .busy(busy),
    .done(done), .underflow(underflow));

  always #5 sys_clk = ~sys_clk;

  // show-ahead FIFO: bench writes wr_ptr, the pop process owns rd_ptr
  logic [13:0] fifo_mem [0:63];
  int          wr_ptr = 0, rd_ptr = 0;
  logic        force_empty = 1'b0;
  assign smp_empty = (rd_ptr == wr_ptr) || force_empty;
  assign smp_data  = fifo_mem[rd_ptr % 64];
  always @(posedge sys_clk) if (smp_rdreq && !smp_empty) rd_ptr <= rd_ptr + 1;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // reference register image
  int m_mode = 1, m_black = 0, m_pl = 7, m_shp_lo = 1, m_shp_hi = 3;
  int m_shd_lo = 5, m_shd_hi = 7, m_clkf = 4, m_cap = 7, m_n = 0;
  int smp [0:63];
  int m_ns, m_E, m_stop;
  bit uf_exp = 1'b0;

  task automatic cfg(input int a, input int d);
    @(negedge sys_clk);
    cfg_wr = 1'b1; cfg_addr = a[2:0]; cfg_data = d[15:0];
    @(negedge sys_clk);
    cfg_wr = 1'b0;
    case (a)
      0: m_mode = d & 1;
      1: m_black = d & 16'h3fff;
      2: m_pl = d & 255;
      3: begin m_shp_hi = (d >> 8) & 255; m_shp_lo = d & 255; end
      4: begin m_shd_hi = (d >> 8) & 255; m_shd_lo = d & 255; end
      5: begin m_cap = (d >> 8) & 255; m_clkf = d & 255; end
      6: m_n = d & 16'hffff;
      default: ;
    endcase
  endtask

  // 0 idle, 1 prime, 2 running, 3 running with stop asserted
  function automatic int kind(input int j, output int t);
    t = j - (m_E + 2);
    if (j <= 0 || m_n == 0) return 0;
    if (j <= m_E + 1) return 1;
    if (m_stop >= 0) begin
      if (t < m_stop) return 2;
      if (t == m_stop) return 3;
      return 0;
    end
    if (t < m_n * (m_pl + 1)) return 2;
    return 0;
  endfunction

  task automatic run(input int ns, input int E, input int stop_t, input bit junk);
    int t, tp, k, kp, p, ph, last, per, adc_prev;
    int e_clk, e_shp, e_shd, e_dac, e_cv, e_done, e_rd;
    wr_ptr = rd_ptr;
    for (int i = 0; i < ns; i++) begin
      smp[i] = int'($urandom & 32'h3fff);
      fifo_mem[wr_ptr % 64] = smp[i][13:0];
      wr_ptr++;
    end
    m_ns = ns; m_E = E; m_stop = stop_t;
    per = m_pl + 1;
    adc_prev = 0;
    last = (m_n == 0) ? 1 : (stop_t >= 0 ? m_E + 2 + stop_t : m_E + 1 + m_n * per);
    for (int j = 0; j <= last + 2; j++) begin
      @(negedge sys_clk);
      kp = kind(j - 1, tp);
      if (kp == 2) begin
        p = tp / per; ph = tp % per;
        e_clk  = int'(ph < m_clkf);
        e_shp  = int'(!(ph >= m_shp_lo && ph < m_shp_hi));
        e_shd  = int'(!(ph >= m_shd_lo && ph < m_shd_hi));
        e_dac  = (m_mode == 1 && ph < m_clkf) ? m_black : smp[(p < m_ns) ? p : m_ns - 1];
        e_cv   = int'(ph == m_cap);
        e_done = int'(m_stop < 0 && tp == m_n * per - 1);
      end else begin
        e_clk = 1; e_shp = 1; e_shd = 1; e_dac = m_black; e_cv = 0;
        e_done = int'(j - 1 == 0 && m_n == 0);
      end
      chk("clk_fpga", clk_fpga, e_clk);
      chk("shp_fpga", shp_fpga, e_shp);
      chk("shd_fpga", shd_fpga, e_shd);
      chk("dac_d", dac_d, e_dac);
      chk("cap_valid", cap_valid, e_cv);
      if (e_cv == 1) chk("cap_data", cap_data, adc_prev);
      chk("done", done, e_done);
      chk("underflow", underflow, uf_exp);
      k = kind(j, t);
      chk("busy", busy, int'(k != 0));
      // inputs for cycle j
      start = (j == 0);
      stop  = (k == 3);
      force_empty = (m_n != 0) && (j >= 1) && (j <= E);
      adc_prev = int'($urandom & 32'hfff);
      adc_q = adc_prev[11:0];
      if (junk && k == 2) begin
        cfg_wr = $urandom_range(0, 1) == 1;
        cfg_addr = 3'($urandom_range(0, 6));
        cfg_data = 16'($urandom);
      end else cfg_wr = 1'b0;
      #1;
      e_rd = 0;
      if (k == 2) begin
        p = t / per; ph = t % per;
        e_rd = int'(ph == 0 && p < m_ns);
      end
      chk("smp_rdreq", smp_rdreq, e_rd);
      if (j == 0 && m_n != 0) uf_exp = 1'b0;
      if (k == 2 && ph == 0 && p >= m_ns) uf_exp = 1'b1;
    end
    start = 1'b0; stop = 1'b0; cfg_wr = 1'b0; force_empty = 1'b0;
  endtask

  initial begin
    int n, pl;
    #2;
    @(negedge sys_clk);
    chk("rst_clk", clk_fpga, 0);   chk("rst_shp", shp_fpga, 0);
    chk("rst_shd", shd_fpga, 0);   chk("rst_dac", dac_d, 0);
    chk("rst_cap", cap_data, 0);   chk("rst_cv", cap_valid, 0);
    chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
    chk("rst_uf", underflow, 0);   chk("rst_rdreq", smp_rdreq, 0);
    n_rst = 1'b1;
    repeat (3) @(negedge sys_clk);

    // reset defaults, 4 pixels of 8 clocks
    cfg(6, 4);
    run(4, 0, -1, 0);
    // plain mode, short period; cap_pos 7 lies beyond per_last, so no capture
    cfg(0, 0); cfg(2, 3); cfg(6, 3); cfg(1, 16'h1a5c);
    run(3, 0, -1, 1);
    // two samples for four pixels: underflow, last sample repeated
    cfg(0, 1); cfg(2, 7); cfg(6, 4); cfg(1, 16'h0123);
    run(2, 0, -1, 1);
    // abort at pixel 2, ph 5
    run(2, 0, 21, 0);
    // zero pixel count: done without PRIME, underflow untouched
    cfg(6, 0);
    run(1, 0, -1, 0);
    // FIFO held empty for 10 cycles in PRIME
    cfg(6, 2);
    run(2, 10, -1, 0);
    // degenerate period: one pixel per clock
    cfg(0, 0); cfg(2, 0); cfg(5, 16'h0001); cfg(6, 5);
    run(5, 0, -1, 0);

    for (int r = 0; r < 10; r++) begin
      pl = $urandom_range(0, 12);
      n  = $urandom_range(1, 6);
      cfg(0, $urandom_range(0, 1));
      cfg(1, int'($urandom & 32'hffff));
      cfg(2, pl);
      cfg(3, ($urandom_range(0, pl + 2) << 8) | $urandom_range(0, pl + 2));
      cfg(4, ($urandom_range(0, pl + 2) << 8) | $urandom_range(0, pl + 2));
      cfg(5, ($urandom_range(0, pl + 2) << 8) | $urandom_range(0, pl + 2));
      cfg(6, n);
      run($urandom_range(1, n + 1), $urandom_range(0, 3),
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, n * (pl + 1) - 1) : -1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
